sha1_padder: RTL and testbench

- Upstream stage of the SHA-1 core.
- Accepts a message as a stream of 32-bit big-endian words over a valid/ready handshake and packs them into 512-bit blocks.
- Applies FIPS 180-4 padding: 0x80 marker byte, zero fill, 64-bit message bit-length.
- Presents each block with a last-block flag. Top level ties block_ready_i to (core hold_o | core idle_o) and drives the core's enable_hash_i from the block handshake.

---
 rtl/sha1_pkg.sv | 17 +
 rtl/sha1_padder_if.sv | 25 ++
 rtl/sha1_pad_word.sv | 28 ++
 rtl/sha1_padder.sv | 192 +++++++++++++++++++
 tb/tb_sha1_padder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        FULL,
        PAD,
        EXTRA
    } pad_state_e;

    localparam int WordSize    = 32;
    localparam int NumWords    = 16;
    localparam int LengthWidth = 64;
    localparam logic [7:0] PadMarker = 8'h80;
    localparam int LenWordIdx  = 14;

endpackage

// File: rtl/sha1_padder_if.sv
// Word-stream input and block output handshakes of the SHA-1 padder.
interface sha1_padder_if;
    import sha1_pkg::*;

    logic [WordSize-1:0]          in_data_i;
    logic [2:0]                   in_bytes_i;
    logic                         in_last_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [NumWords*WordSize-1:0] block_o;
    logic                         block_last_o;
    logic                         block_valid_o;
    logic                         block_ready_i;

    modport slave (
        input  in_data_i, in_bytes_i, in_last_i, in_valid_i, block_ready_i,
        output in_ready_o, block_o, block_last_o, block_valid_o
    );

    modport master (
        output in_data_i, in_bytes_i, in_last_i, in_valid_i, block_ready_i,
        input  in_ready_o, block_o, block_last_o, block_valid_o
    );

endinterface

// File: rtl/sha1_pad_word.sv
// Masks the final message word to its valid bytes and places the 0x80 marker
// in the first free byte, or flags that the marker spills into the next word.
module sha1_pad_word import sha1_pkg::*; (
    input  logic [WordSize-1:0] data_i,
    input  logic [2:0]          bytes_i,
    output logic [WordSize-1:0] word_o,
    output logic                marker_in_next_o,
    output logic [2:0]          bytes_o
);

    logic [2:0] n;

    always_comb begin
        // Byte counts above a full word saturate to a full word
        n      = (bytes_i > 3'd4) ? 3'd4 : bytes_i;
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < n) begin
                word_o[WordSize-1-8*b -: 8] = data_i[WordSize-1-8*b -: 8];
            end else if (3'(b) == n) begin
                word_o[WordSize-1-8*b -: 8] = PadMarker;
            end
        end
        marker_in_next_o = (n == 3'd4);
        bytes_o          = n;
    end

endmodule

// File: rtl/sha1_padder.sv
// Packs a big-endian word stream into 512-bit SHA-1 blocks and appends the
// 0x80 marker, zero fill and 64-bit bit length, adding an extra block if needed.
module sha1_padder #(
    parameter int BlockWidth  = 512,
    parameter int WordSize    = 32,
    parameter int LengthWidth = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    sha1_padder_if.slave bus
);
    import sha1_pkg::*;

    localparam int NumW = BlockWidth / WordSize;
    localparam int CntW = LengthWidth - 3;
    localparam int IdxW = $clog2(NumW);

    typedef logic [WordSize-1:0] word_t;

    function automatic logic [LengthWidth-1:0] bit_len(input logic [CntW-1:0] bytes);
        return {bytes, 3'b000};
    endfunction

    pad_state_e        state_q, state_d;
    word_t             words_q [NumW];
    word_t             words_d [NumW];
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   len_q, len_d;
    logic              pad_pending_q, pad_pending_d;
    logic              last_q, last_d;

    word_t             pad_word;
    logic              marker_in_next;
    logic [2:0]        n_bytes;

    sha1_pad_word u_pad_word (
        .data_i           (bus.in_data_i),
        .bytes_i          (bus.in_bytes_i),
        .word_o           (pad_word),
        .marker_in_next_o (marker_in_next),
        .bytes_o          (n_bytes)
    );

    logic [CntW-1:0]        len_add;
    logic [LengthWidth-1:0] len_bits_cur;
    logic [LengthWidth-1:0] len_bits_new;
    logic [IdxW-1:0]        idx_nx;
    logic [IdxW:0]          marker_idx;
    logic                   load_extra;
    logic                   finish_msg;

    assign len_add      = len_q + CntW'(n_bytes);
    assign len_bits_cur = bit_len(len_q);
    assign len_bits_new = bit_len(len_add);
    assign idx_nx       = idx_q + IdxW'(1);
    assign marker_idx   = {1'b0, idx_q} + (IdxW+1)'(marker_in_next);

    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        idx_d         = idx_q;
        len_d         = len_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        load_extra    = 1'b0;
        finish_msg    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (bus.in_valid_i) begin
                    if (!bus.in_last_i) begin
                        words_d[idx_q] = bus.in_data_i;
                        idx_d          = idx_nx;
                        len_d          = len_q + CntW'(4);
                        if (idx_q == IdxW'(NumW-1)) begin
                            state_d       = FULL;
                            last_d        = 1'b0;
                            pad_pending_d = 1'b0;
                        end
                    end else if (idx_q == IdxW'(NumW-1) && marker_in_next) begin
                        // Block is exactly full: marker and length go in an extra block
                        words_d[idx_q] = pad_word;
                        len_d          = len_add;
                        state_d        = FULL;
                        pad_pending_d  = 1'b1;
                        last_d         = 1'b0;
                    end else begin
                        len_d = len_add;
                        for (int k = 0; k < NumW; k++) begin
                            if (k > int'(idx_q)) words_d[k] = '0;
                        end
                        words_d[idx_q] = pad_word;
                        if (marker_in_next) words_d[idx_nx] = {PadMarker, {(WordSize-8){1'b0}}};
                        if (marker_idx <= (IdxW+1)'(LenWordIdx-1)) begin
                            words_d[LenWordIdx]   = len_bits_new[LengthWidth-1 -: WordSize];
                            words_d[LenWordIdx+1] = len_bits_new[WordSize-1:0];
                            last_d                = 1'b1;
                        end else begin
                            last_d = 1'b0;
                        end
                        state_d = PAD;
                    end
                end
            end
            FULL: begin
                if (bus.block_ready_i) begin
                    if (pad_pending_q) begin
                        state_d    = EXTRA;
                        load_extra = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        idx_d   = '0;
                    end
                end
            end
            PAD: begin
                if (bus.block_ready_i) begin
                    if (last_q) begin
                        state_d    = COLLECT;
                        finish_msg = 1'b1;
                    end else begin
                        state_d    = EXTRA;
                        load_extra = 1'b1;
                    end
                end
            end
            EXTRA: begin
                if (bus.block_ready_i) begin
                    state_d    = COLLECT;
                    finish_msg = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (load_extra) begin
            for (int k = 0; k < NumW; k++) words_d[k] = '0;
            words_d[0]            = pad_pending_q ? {PadMarker, {(WordSize-8){1'b0}}} : '0;
            words_d[LenWordIdx]   = len_bits_cur[LengthWidth-1 -: WordSize];
            words_d[LenWordIdx+1] = len_bits_cur[WordSize-1:0];
            last_d                = 1'b1;
        end

        if (finish_msg) begin
            len_d         = '0;
            idx_d         = '0;
            pad_pending_d = 1'b0;
            last_d        = 1'b0;
        end

        // Soft clear overrides everything, including an in-flight block
        if (clear_i) begin
            state_d = COLLECT;
            for (int k = 0; k < NumW; k++) words_d[k] = '0;
            idx_d         = '0;
            len_d         = '0;
            pad_pending_d = 1'b0;
            last_d        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            for (int k = 0; k < NumW; k++) words_q[k] <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_q       <= words_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
        end
    end

    always_comb begin
        bus.block_o = '0;
        for (int k = 0; k < NumW; k++) begin
            bus.block_o[BlockWidth-1-WordSize*k -: WordSize] = words_q[k];
        end
    end

    assign bus.in_ready_o    = (state_q == COLLECT);
    assign bus.block_valid_o = (state_q != COLLECT);
    assign bus.block_last_o  = last_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: table of message lengths against a byte-level
// padding reference, plus hand-written backpressure and clear sequences.
module tb_sha1_padder;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;

    always #5 clk_i = ~clk_i;

    sha1_padder_if bus ();

    sha1_padder dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        int          nblk;
        int          mblk;
        int          mword;
        logic [31:0] mval;
        logic [31:0] w15;
    } vec_t;

    vec_t        vecs [10];
    logic [511:0] got_blk  [8];
    logic         got_last [8];
    int           got_n;

    localparam logic [511:0] AbcExp   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EmptyExp = {32'h80000000, 480'h0};

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Standard byte-oriented padding: message bytes k -> k mod 256
    function automatic logic [511:0] ref_block(input int len, input int b);
        logic [511:0] r;
        logic [63:0]  bits;
        logic [7:0]   v;
        int           total;
        int           p;
        total = ((len + 8) / 64 + 1) * 64;
        bits  = 64'(len) * 64'd8;
        r     = '0;
        for (int j = 0; j < 64; j++) begin
            p = b * 64 + j;
            if (p < len)             v = p[7:0];
            else if (p == len)       v = 8'h80;
            else if (p >= total - 8) v = 8'(bits >> (8 * (total - 1 - p)));
            else                     v = 8'h00;
            r[511-8*j -: 8] = v;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the word is accepted
    task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
        int cnt;
        bus.in_data_i  = d;
        bus.in_bytes_i = b;
        bus.in_last_i  = l;
        bus.in_valid_i = 1'b1;
        cnt = 0;
        while (!bus.in_ready_o && cnt < 300) begin
            @(negedge clk_i);
            cnt++;
        end
        if (cnt >= 300) begin
            chk32("send_timeout", 32'(cnt), 32'd0);
        end
        @(negedge clk_i);
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic send_msg(input int len);
        int          nw;
        int          n;
        int          p;
        logic [31:0] d;
        logic [2:0]  bb;
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            n = (w == nw - 1) ? len - 4 * w : 0;
            for (int q = 0; q < 4; q++) begin
                p = 4 * w + q;
                d[31-8*q -: 8] = (p < len) ? p[7:0] : 8'hAA;
            end
            if (w != nw - 1)            bb = 3'(w);
            else if (n == 4 && len > 100) bb = 3'd7;
            else                        bb = 3'(n);
            send_word(d, bb, w == nw - 1);
        end
    endtask

    task automatic recv_blocks();
        int cyc;
        got_n = 0;
        cyc   = 0;
        bus.block_ready_i = 1'b1;
        while (got_n < 8 && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (bus.block_valid_o) begin
                got_blk[got_n]  = bus.block_o;
                got_last[got_n] = bus.block_last_o;
                got_n++;
                if (bus.block_last_o) break;
            end
        end
        if (cyc >= 400) chk32("recv_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_abc(input string nm);
        fork
            send_word(32'h61626300, 3'd3, 1'b1);
            recv_blocks();
        join
        @(negedge clk_i);
        chk32({nm, "_nblk"}, 32'(got_n), 32'd1);
        chk({nm, "_block"}, got_blk[0], AbcExp);
        chk32({nm, "_last"}, {31'b0, got_last[0]}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] held;

        bus.in_data_i     = '0;
        bus.in_bytes_i    = '0;
        bus.in_last_i     = 1'b0;
        bus.in_valid_i    = 1'b0;
        bus.block_ready_i = 1'b0;

        vecs[0] = '{0,   1, 0, 0,  32'h80000000, 32'h00000000};
        vecs[1] = '{3,   1, 0, 0,  32'h00010280, 32'h00000018};
        vecs[2] = '{55,  1, 0, 13, 32'h34353680, 32'h000001B8};
        vecs[3] = '{56,  2, 0, 14, 32'h80000000, 32'h000001C0};
        vecs[4] = '{57,  2, 0, 14, 32'h38800000, 32'h000001C8};
        vecs[5] = '{60,  2, 0, 15, 32'h80000000, 32'h000001E0};
        vecs[6] = '{64,  2, 1, 0,  32'h80000000, 32'h00000200};
        vecs[7] = '{65,  2, 1, 0,  32'h40800000, 32'h00000208};
        vecs[8] = '{119, 2, 1, 13, 32'h74757680, 32'h000003B8};
        vecs[9] = '{128, 3, 2, 0,  32'h80000000, 32'h00000400};

        repeat (2) @(negedge clk_i);
        chk32("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
        chk32("rst_block_valid", {31'b0, bus.block_valid_o}, 32'd0);
        chk32("rst_block_last", {31'b0, bus.block_last_o}, 32'd0);
        chk("rst_block", bus.block_o, '0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_abc("abc");

        // Empty message
        fork
            send_word(32'hDEADBEEF, 3'd0, 1'b1);
            recv_blocks();
        join
        @(negedge clk_i);
        chk32("empty_nblk", 32'(got_n), 32'd1);
        chk("empty_block", got_blk[0], EmptyExp);
        chk32("empty_last", {31'b0, got_last[0]}, 32'd1);

        for (int v = 0; v < 10; v++) begin
            fork
                send_msg(vecs[v].len);
                recv_blocks();
            join
            @(negedge clk_i);
            chk32($sformatf("len%0d_nblk", vecs[v].len), 32'(got_n), 32'(vecs[v].nblk));
            for (int b = 0; b < vecs[v].nblk && b < got_n; b++) begin
                chk($sformatf("len%0d_blk%0d", vecs[v].len, b), got_blk[b], ref_block(vecs[v].len, b));
                chk32($sformatf("len%0d_last%0d", vecs[v].len, b), {31'b0, got_last[b]},
                      (b == vecs[v].nblk - 1) ? 32'd1 : 32'd0);
            end
            if (got_n == vecs[v].nblk) begin
                held = got_blk[vecs[v].mblk];
                chk32($sformatf("len%0d_marker", vecs[v].len),
                      held[511-32*vecs[v].mword -: 32], vecs[v].mval);
                held = got_blk[got_n-1];
                chk32($sformatf("len%0d_w15", vecs[v].len), held[31:0], vecs[v].w15);
            end
        end

        // Backpressure: block must hold steady and input must stall
        bus.block_ready_i = 1'b0;
        send_word(32'h61626300, 3'd3, 1'b1);
        chk32("bp_valid", {31'b0, bus.block_valid_o}, 32'd1);
        held = bus.block_o;
        chk("bp_block", held, AbcExp);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk($sformatf("bp_stable%0d", c), bus.block_o, held);
            chk32($sformatf("bp_in_ready%0d", c), {31'b0, bus.in_ready_o}, 32'd0);
            chk32($sformatf("bp_valid%0d", c), {31'b0, bus.block_valid_o}, 32'd1);
        end
        bus.block_ready_i = 1'b1;
        @(negedge clk_i);
        chk32("bp_release_valid", {31'b0, bus.block_valid_o}, 32'd0);
        chk32("bp_release_ready", {31'b0, bus.in_ready_o}, 32'd1);

        // Clear while a full block is waiting
        bus.block_ready_i = 1'b0;
        send_msg(64);
        chk32("clr_pre_valid", {31'b0, bus.block_valid_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk32("clr_valid", {31'b0, bus.block_valid_o}, 32'd0);
        chk32("clr_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
        chk("clr_block", bus.block_o, '0);
        run_abc("clr_abc");

        // Clear partway through collecting a message
        bus.block_ready_i = 1'b1;
        for (int w = 0; w < 5; w++) send_word(32'h11223344, 3'd4, 1'b0);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        run_abc("abort_abc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
